// File: rtl/video_packet_tx.sv
// Frames an RGB pixel stream into Avalon-ST video packets: header (type 0, sop), IMAGE_W*IMAGE_H pixels, eop on last.
// Latency: 2 cycles from input transfer to output beat; sustained 1 beat/cycle. Backpressure: out_ready stalls FSM, FIFO fills, in_ready drops.
// Optional: define VIDEO_TX_CTRL_PKT_EN to send a control packet (width/height) before every video packet.
module video_packet_tx #(
    parameter int IMAGE_W    = 640,
    parameter int IMAGE_H    = 480,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  in_red,
    input  logic [7:0]  in_green,
    input  logic [7:0]  in_blue,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [23:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sop,
    output logic        out_eop,
    output logic        frame_done
);
    localparam int          AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);
    localparam logic [11:0] X_LAST   = 12'(IMAGE_W - 1);
    localparam logic [11:0] Y_LAST   = 12'(IMAGE_H - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_VID_HDR = 3'd3;
    localparam logic [2:0] ST_PIXELS  = 3'd4;
`ifdef VIDEO_TX_CTRL_PKT_EN
    localparam logic [2:0]  ST_CTRL_HDR  = 3'd1;
    localparam logic [2:0]  ST_CTRL_DATA = 3'd2;
    localparam logic [15:0] W16 = 16'(IMAGE_W);
    localparam logic [15:0] H16 = 16'(IMAGE_H);
    localparam logic [23:0] CTRL_B1 = {4'h0, W16[7:4], 4'h0, W16[11:8], 4'h0, W16[15:12]};
    localparam logic [23:0] CTRL_B2 = {4'h0, H16[11:8], 4'h0, H16[15:12], 4'h0, W16[3:0]};
    localparam logic [23:0] CTRL_B3 = {4'h0, 4'h0, 4'h0, H16[3:0], 4'h0, H16[7:4]};
    logic [1:0] ctrl_idx_q, ctrl_idx_d;
`endif

    logic [23:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push, pop;
    logic          in_ready_q, in_ready_d;

    logic [2:0]    state_q, state_d;
    logic [11:0]   x_q, x_d, y_q, y_d;
    logic          ov_q, ov_d, sop_q, sop_d, eop_q, eop_d, fd_q, fd_d;
    logic [23:0]   od_q, od_d;

    logic          xfer, last_px, can_load, src_ok;
    logic [11:0]   nx, ny;
    logic [23:0]   src_dat;

    assign push    = in_valid && in_ready_q;
    assign rd_nxt  = rd_ptr_q + 1'b1;
    assign cnt_d   = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    assign in_ready_d = (cnt_d != FULL_CNT);
    assign xfer    = ov_q && out_ready;
    assign last_px = (x_q == X_LAST) && (y_q == Y_LAST);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_blue, in_green, in_red};
        end
    end

    // The presented pixel stays in the FIFO until it transfers, so a refill
    // on transfer must come from the entry behind the head.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        ov_d     = ov_q;
        od_d     = od_q;
        sop_d    = sop_q;
        eop_d    = eop_q;
        fd_d     = 1'b0;
        pop      = 1'b0;
        nx       = x_q;
        ny       = y_q;
        can_load = 1'b0;
        src_ok   = 1'b0;
        src_dat  = mem_q[rd_ptr_q];
`ifdef VIDEO_TX_CTRL_PKT_EN
        ctrl_idx_d = ctrl_idx_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef VIDEO_TX_CTRL_PKT_EN
                state_d    = ST_CTRL_HDR;
                od_d       = 24'h00000F;
                ctrl_idx_d = 2'd0;
`else
                state_d    = ST_VID_HDR;
                od_d       = 24'h000000;
`endif
                ov_d  = 1'b1;
                sop_d = 1'b1;
                eop_d = 1'b0;
            end
`ifdef VIDEO_TX_CTRL_PKT_EN
            ST_CTRL_HDR: begin
                if (xfer) begin
                    state_d    = ST_CTRL_DATA;
                    od_d       = CTRL_B1;
                    sop_d      = 1'b0;
                    ctrl_idx_d = 2'd1;
                end
            end
            ST_CTRL_DATA: begin
                if (xfer) begin
                    if (ctrl_idx_q == 2'd3) begin
                        state_d = ST_VID_HDR;
                        od_d    = 24'h000000;
                        sop_d   = 1'b1;
                        eop_d   = 1'b0;
                    end else if (ctrl_idx_q == 2'd1) begin
                        od_d       = CTRL_B2;
                        ctrl_idx_d = 2'd2;
                    end else begin
                        od_d       = CTRL_B3;
                        eop_d      = 1'b1;
                        ctrl_idx_d = 2'd3;
                    end
                end
            end
`endif
            ST_VID_HDR: begin
                if (xfer) begin
                    state_d  = ST_PIXELS;
                    sop_d    = 1'b0;
                    can_load = 1'b1;
                    src_ok   = (cnt_q != '0);
                end
            end
            ST_PIXELS: begin
                if (xfer) begin
                    pop = 1'b1;
                    if (last_px) begin
                        x_d     = '0;
                        y_d     = '0;
                        state_d = ST_IDLE;
                        ov_d    = 1'b0;
                        eop_d   = 1'b0;
                        fd_d    = 1'b1;
                    end else begin
                        if (x_q == X_LAST) begin
                            nx = '0;
                            ny = y_q + 12'd1;
                        end else begin
                            nx = x_q + 12'd1;
                        end
                        x_d      = nx;
                        y_d      = ny;
                        can_load = 1'b1;
                        src_ok   = (cnt_q > ONE_CNT);
                        src_dat  = mem_q[rd_nxt];
                    end
                end else if (!ov_q) begin
                    can_load = 1'b1;
                    src_ok   = (cnt_q != '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (can_load) begin
            ov_d  = src_ok;
            eop_d = src_ok && (nx == X_LAST) && (ny == Y_LAST);
            if (src_ok) begin
                od_d = src_dat;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            ov_q       <= 1'b0;
            od_q       <= '0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            fd_q       <= 1'b0;
`ifdef VIDEO_TX_CTRL_PKT_EN
            ctrl_idx_q <= '0;
`endif
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_nxt;
            end
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            ov_q       <= ov_d;
            od_q       <= od_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            fd_q       <= fd_d;
`ifdef VIDEO_TX_CTRL_PKT_EN
            ctrl_idx_q <= ctrl_idx_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = ov_q;
    assign out_data   = od_q;
    assign out_sop    = sop_q;
    assign out_eop    = eop_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_video_packet_tx.sv
// Directed bench for video_packet_tx with a beat scoreboard (4x2 frames, 16-entry FIFO).
module tb_video_packet_tx;
    localparam int W    = 4;
    localparam int H    = 2;
    localparam int D    = 16;
    localparam int FPIX = W * H;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  in_red, in_green, in_blue;
    logic        in_valid, in_ready;
    logic [23:0] out_data;
    logic        out_valid, out_ready, out_sop, out_eop, frame_done;

    always #5 clk = ~clk;

    video_packet_tx #(.IMAGE_W(W), .IMAGE_H(H), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sop(out_sop), .out_eop(out_eop), .frame_done(frame_done)
    );

    int total = 0;
    int bad   = 0;
    logic [25:0] sbq[$];   // {sop, eop, data}
    int   pushed    = 0;
    int   fd_count  = 0;
    int   pix_xfers = 0;
    logic rdy_s     = 1'b0;
    logic toggle    = 1'b0;
    logic held_vld  = 1'b0;
    logic [25:0] held = '0;
    logic fd_exp    = 1'b0;
    logic in_vid    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pix(input int v);
        logic [7:0] r;
        r = v[7:0];
        return {~r, r + 8'd100, r};
    endfunction

    task automatic sb_hdr();
`ifdef VIDEO_TX_CTRL_PKT_EN
        logic [15:0] w16, h16;
        w16 = 16'(W);
        h16 = 16'(H);
        sbq.push_back({2'b10, 24'h00000F});
        sbq.push_back({2'b00, 4'h0, w16[7:4], 4'h0, w16[11:8], 4'h0, w16[15:12]});
        sbq.push_back({2'b00, 4'h0, h16[11:8], 4'h0, h16[15:12], 4'h0, w16[3:0]});
        sbq.push_back({2'b01, 8'h00, 4'h0, h16[3:0], 4'h0, h16[7:4]});
`endif
        sbq.push_back({2'b10, 24'h000000});
    endtask

    task automatic sb_px(input logic [23:0] d);
        int p;
        p = pushed % FPIX;
        sbq.push_back({1'b0, (p == FPIX - 1), d});
        pushed++;
        if (p == FPIX - 1) sb_hdr();
    endtask

    task automatic tick();
        @(negedge clk);
        rdy_s = in_ready;
        @(posedge clk);
        #1;
        if (toggle) out_ready = ~out_ready;
    endtask

    task automatic send_px(input int v);
        int   n;
        logic ok;
        n = 0;
        ok = 1'b0;
        {in_blue, in_green, in_red} = pix(v);
        in_valid = 1'b1;
        while (!ok && n < 2000) begin
            tick();
            ok = rdy_s;
            n++;
        end
        if (ok) sb_px(pix(v));
        else chk("send_timeout", 32'(n), 32'(0));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 1000) begin
            tick();
            n++;
        end
        chk("drain_left", 32'(sbq.size()), 32'(0));
        tick();
        tick();
    endtask

    // Monitor: scoreboard pop on transfer, stall stability, frame_done timing.
    always @(negedge clk) begin
        logic [25:0] exp;
        if (!reset_n) begin
            held_vld = 1'b0;
            fd_exp   = 1'b0;
            in_vid   = 1'b0;
        end else begin
            chk("frame_done", 32'(frame_done), 32'(fd_exp));
            if (frame_done) fd_count++;
            if (held_vld) begin
                chk("stall_valid", 32'(out_valid), 32'(1));
                chk("stall_beat", 32'({out_sop, out_eop, out_data}), 32'(held));
            end
            if (out_valid && out_ready) begin
                total++;
                assert (sbq.size() != 0) else begin
                    bad++;
                    $error("FAIL unexpected_beat: observed=%h expected=none", {out_sop, out_eop, out_data});
                end
                if (sbq.size() != 0) begin
                    exp = sbq.pop_front();
                    chk("beat", 32'({out_sop, out_eop, out_data}), 32'(exp));
                end
                if (out_sop) in_vid = (out_data == 24'h0);
                else pix_xfers++;
                fd_exp   = in_vid && out_eop;
                held_vld = 1'b0;
            end else begin
                fd_exp   = 1'b0;
                held_vld = out_valid;
                held     = {out_sop, out_eop, out_data};
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, fd0, p0, n;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_red    = '0;
        in_green  = '0;
        in_blue   = '0;
        out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_sop", 32'(out_sop), 32'(0));
        chk("rst_out_eop", 32'(out_eop), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_frame_done", 32'(frame_done), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        sb_hdr();
        tick();
        chk("in_ready_after_rst", 32'(in_ready), 32'(1));

        // FIFO fill with header stalled: exactly D pixels accepted.
        acc = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            {in_blue, in_green, in_red} = pix(acc);
            tick();
            if (rdy_s && acc < 20) begin
                sb_px(pix(acc));
                acc++;
            end
        end
        chk("fill_accepted", 32'(acc), 32'(D));
        chk("fill_in_ready", 32'(in_ready), 32'(0));
        out_ready = 1'b1;
        for (int v = 16; v < 24; v++) send_px(v);
        in_valid = 1'b0;
        drain();
        chk("fill_frames", 32'(fd_count), 32'(3));

        // Single frame, back-to-back, out_ready high.
        fd0 = fd_count;
        for (int v = 100; v < 100 + FPIX; v++) send_px(v);
        in_valid = 1'b0;
        drain();
        chk("basic_fd", 32'(fd_count - fd0), 32'(1));

        // out_ready toggling every cycle.
        fd0 = fd_count;
        toggle = 1'b1;
        for (int v = 120; v < 120 + FPIX; v++) send_px(v);
        in_valid = 1'b0;
        drain();
        toggle = 1'b0;
        out_ready = 1'b1;
        chk("toggle_fd", 32'(fd_count - fd0), 32'(1));

        // Two frames streamed continuously.
        fd0 = fd_count;
        for (int v = 140; v < 140 + 2 * FPIX; v++) send_px(v);
        in_valid = 1'b0;
        drain();
        chk("two_frames_fd", 32'(fd_count - fd0), 32'(2));

        // Reset in the middle of a frame.
        out_ready = 1'b0;
        for (int v = 180; v < 180 + FPIX; v++) send_px(v);
        in_valid = 1'b0;
        p0 = pix_xfers;
        out_ready = 1'b1;
        n = 0;
        while ((pix_xfers - p0) < 3 && n < 100) begin
            tick();
            n++;
        end
        chk("mid_reach3", 32'((pix_xfers - p0) >= 3), 32'(1));
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'(0));
        chk("mid_rst_sop", 32'(out_sop), 32'(0));
        chk("mid_rst_eop", 32'(out_eop), 32'(0));
        chk("mid_rst_data", 32'(out_data), 32'(0));
        chk("mid_rst_in_ready", 32'(in_ready), 32'(0));
        sbq.delete();
        pushed = 0;
        tick();
        tick();
        reset_n = 1'b1;
        sb_hdr();
        fd0 = fd_count;
        for (int v = 200; v < 200 + FPIX; v++) send_px(v);
        in_valid = 1'b0;
        drain();
        chk("post_rst_fd", 32'(fd_count - fd0), 32'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
